compressed_activation_reader: RTL and testbench

Downstream consumer of the output accumulator's compressed OARAM image (length word plus run-length value/zero-count pairs). It reads one completed OARAM image and expands it into a stream of non-zero activations, each tagged with absolute tile row/column. The stream feeds the next layer's input-activation distributor over a valid/ready handshake. It does not modify the RAM.

---
 rtl/bitfuscnn_pkg.sv | 34 +++
 rtl/activation_skid_fifo.sv | 41 ++++
 rtl/compressed_activation_reader.sv | 185 ++++++++++++++++++
 tb/tb_compressed_activation_reader.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitfuscnn_pkg.sv
// Shared definitions for the accumulator/reader pair: bitwidth encoding,
// tile geometry helper and the compressed OARAM entry layout.
package bitfuscnn_pkg;

  localparam logic [1:0] BW_FULL     = 2'd0;
  localparam logic [1:0] BW_HALF     = 2'd1;
  localparam logic [1:0] BW_EIGHTH   = 2'd2;
  localparam logic [1:0] BW_FULL_ALT = 2'd3;

  localparam int OARAM_LEN_ADDR = 0;
  localparam int ENTRY_VALUE_W  = 25;
  localparam int ENTRY_INDEX_W  = 4;

  typedef struct packed {
    logic [ENTRY_VALUE_W-1:0] value;
    logic [ENTRY_INDEX_W-1:0] zero_run;
  } oaram_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEN,
    ST_STREAM,
    ST_FINISH
  } reader_state_e;

  function automatic int tile_size_from_bitwidth(input logic [1:0] bw, input int full_size);
    case (bw)
      BW_HALF:   return full_size >> 1;
      BW_EIGHTH: return full_size >> 3;
      default:   return full_size;
    endcase
  endfunction

endpackage

// File: rtl/activation_skid_fifo.sv
// Two-entry FIFO between the OARAM read return and the activation stream.
// Control state resets; payload storage does not.
module activation_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             pop;

  assign valid = (count != 2'd0);
  assign data  = mem[rd_ptr];
  assign pop   = valid && ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/compressed_activation_reader.sv
// Walks one compressed OARAM image (length word + value/zero-run pairs) and
// streams its non-zero activations with absolute tile coordinates.
module compressed_activation_reader
  import bitfuscnn_pkg::*;
#(
  parameter int RAM_WIDTH   = 10,
  parameter int TILE_SIZE   = 256,
  parameter int INDEX_WIDTH = ENTRY_INDEX_W,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [1:0]                   bitwidth,
  input  logic [2:0]                   kernel_size,
  input  logic                         start,
  output logic                         oaram_read_enable,
  output logic [RAM_WIDTH-2:0]         oaram_read_address,
  input  logic [24:0]                  oaram_value,
  input  logic [INDEX_WIDTH-1:0]       oaram_indices_value,
  output logic                         act_valid,
  input  logic                         act_ready,
  output logic [DATA_WIDTH-1:0]        act_value,
  output logic [$clog2(TILE_SIZE)-1:0] act_row,
  output logic [$clog2(TILE_SIZE)-1:0] act_column,
  output logic                         act_last,
  output logic                         busy,
  output logic                         done
);

  localparam int ADDR_W  = RAM_WIDTH - 1;
  localparam int COORD_W = $clog2(TILE_SIZE);
  localparam int GEO_W   = COORD_W + 1;
  localparam int PAY_W   = 1 + 2 * COORD_W + DATA_WIDTH;
  localparam logic [ADDR_W-1:0] MAX_LEN = '1;

  function automatic logic [ADDR_W-1:0] clamp_length(input logic [24:0] raw);
    if (|(raw >> ADDR_W)) return MAX_LEN;
    return raw[ADDR_W-1:0];
  endfunction

  reader_state_e state, state_next;

  logic [ADDR_W-1:0]    len;
  logic [ADDR_W-1:0]    len_in;
  logic [RAM_WIDTH-1:0] ptr;
  logic [COORD_W-1:0]   halo, halo_in;
  logic [GEO_W-1:0]     center_w, center_w_in, tile_in;
  logic [2:0]           kernel_m1;
  logic [COORD_W-1:0]   row_cnt, row_pos, row_adv;
  logic [GEO_W-1:0]     col_cnt, col_sum, col_pos, col_inc, col_adv;
  logic                 wrap_pos, wrap_adv;
  logic                 accept_start, issue, pop, last_accept;
  logic [1:0]           occupancy;
  logic                 rd_vld_p1, rd_last_p1;
  oaram_entry_t         entry_p1;

  logic             push;
  logic [PAY_W-1:0] push_data;
  logic             fifo_valid;
  logic [PAY_W-1:0] fifo_data;
  logic [1:0]       fifo_count;

  assign accept_start = (state == ST_IDLE) && start;
  assign len_in       = clamp_length(oaram_value);
  assign pop          = fifo_valid && act_ready;
  assign last_accept  = pop && fifo_data[PAY_W-1];
  // The slot being popped this cycle is free for a new read, which keeps 1 entry/cycle.
  assign occupancy    = fifo_count - 2'(pop) + 2'(rd_vld_p1);
  assign issue        = (state == ST_STREAM) && (ptr <= {1'b0, len}) && (occupancy < 2'd2);

  always_comb begin
    kernel_m1   = kernel_size - 3'd1;
    halo_in     = COORD_W'(kernel_m1 >> 1);
    tile_in     = GEO_W'(tile_size_from_bitwidth(bitwidth, TILE_SIZE));
    center_w_in = tile_in - (GEO_W'(halo_in) << 1);
  end

  always_comb begin
    state_next         = state;
    oaram_read_enable  = 1'b0;
    oaram_read_address = '0;
    busy               = 1'b0;
    done               = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          oaram_read_enable  = 1'b1;
          oaram_read_address = ADDR_W'(OARAM_LEN_ADDR);
          state_next         = ST_LEN;
        end
      end
      ST_LEN: begin
        busy       = 1'b1;
        state_next = (len_in == '0) ? ST_FINISH : ST_STREAM;
      end
      ST_STREAM: begin
        busy = 1'b1;
        if (issue) begin
          oaram_read_enable  = 1'b1;
          oaram_read_address = ptr[ADDR_W-1:0];
        end
        if (last_accept) state_next = ST_FINISH;
      end
      ST_FINISH: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // p1: read data returns; place the entry and advance the center-relative cursor
  assign entry_p1.value    = oaram_value;
  assign entry_p1.zero_run = oaram_indices_value;

  always_comb begin
    col_sum  = col_cnt + GEO_W'(entry_p1.zero_run);
    wrap_pos = (col_sum >= center_w);
    col_pos  = wrap_pos ? (col_sum - center_w) : col_sum;
    row_pos  = row_cnt + COORD_W'(wrap_pos);
    col_inc  = col_pos + GEO_W'(1);
    wrap_adv = (col_inc >= center_w);
    col_adv  = wrap_adv ? (col_inc - center_w) : col_inc;
    row_adv  = row_pos + COORD_W'(wrap_adv);
  end

  assign push      = rd_vld_p1 && ((entry_p1.value != '0) || rd_last_p1);
  assign push_data = {rd_last_p1, halo + row_pos, halo + col_pos[COORD_W-1:0],
                      entry_p1.value[DATA_WIDTH-1:0]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      len        <= '0;
      ptr        <= '0;
      rd_vld_p1  <= 1'b0;
      rd_last_p1 <= 1'b0;
      row_cnt    <= '0;
      col_cnt    <= '0;
    end else begin
      state      <= state_next;
      rd_vld_p1  <= issue;
      rd_last_p1 <= issue && (ptr[ADDR_W-1:0] == len);
      if (state == ST_LEN) begin
        len <= len_in;
        ptr <= RAM_WIDTH'(1);
      end else if (issue) begin
        ptr <= ptr + RAM_WIDTH'(1);
      end
      if (accept_start) begin
        row_cnt <= '0;
        col_cnt <= '0;
      end else if (rd_vld_p1) begin
        row_cnt <= row_adv;
        col_cnt <= col_adv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept_start) begin
      halo     <= halo_in;
      center_w <= center_w_in;
    end
  end

  // p2: buffered stream entry presented to the consumer
  activation_skid_fifo #(.WIDTH(PAY_W)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .ready     (act_ready),
    .valid     (fifo_valid),
    .data      (fifo_data),
    .count     (fifo_count)
  );

  assign act_valid  = fifo_valid;
  assign act_value  = fifo_valid ? fifo_data[DATA_WIDTH-1:0] : '0;
  assign act_column = fifo_valid ? fifo_data[DATA_WIDTH +: COORD_W] : '0;
  assign act_row    = fifo_valid ? fifo_data[DATA_WIDTH+COORD_W +: COORD_W] : '0;
  assign act_last   = fifo_valid && fifo_data[PAY_W-1];

endmodule

// File: tb/tb_compressed_activation_reader.sv
// Directed bench for compressed_activation_reader: table of images with
// hand-computed streams plus reset, max-length and start-while-busy sequences.
module tb_compressed_activation_reader;

  localparam int IMG_DENSE = 0, IMG_WRAP = 1, IMG_PAD = 2, IMG_EMPTY = 3, IMG_MAX = 4;

  typedef struct packed {
    logic [15:0] value;
    logic [7:0]  row;
    logic [7:0]  col;
    logic        last;
  } ent_t;

  typedef struct packed {
    logic [1:0] bw;
    logic [2:0] k;
    logic [1:0] mode;
    logic [2:0] img;
    logic       extra;
    logic [2:0] n_exp;
    ent_t [3:0] ent;
  } case_t;

  logic        clk, reset_n, start, act_ready;
  logic [1:0]  bitwidth;
  logic [2:0]  kernel_size;
  logic        oaram_read_enable;
  logic [8:0]  oaram_read_address;
  logic [24:0] oaram_value;
  logic [3:0]  oaram_indices_value;
  logic        act_valid, act_last, busy, done;
  logic [15:0] act_value;
  logic [7:0]  act_row, act_column;

  compressed_activation_reader dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .bitwidth            (bitwidth),
    .kernel_size         (kernel_size),
    .start               (start),
    .oaram_read_enable   (oaram_read_enable),
    .oaram_read_address  (oaram_read_address),
    .oaram_value         (oaram_value),
    .oaram_indices_value (oaram_indices_value),
    .act_valid           (act_valid),
    .act_ready           (act_ready),
    .act_value           (act_value),
    .act_row             (act_row),
    .act_column          (act_column),
    .act_last            (act_last),
    .busy                (busy),
    .done                (done)
  );

  logic [24:0] ram_val [512];
  logic [3:0]  ram_idx [512];

  always @(posedge clk) begin
    if (oaram_read_enable) begin
      oaram_value         <= ram_val[oaram_read_address];
      oaram_indices_value <= ram_idx[oaram_read_address];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int ready_mode = 0;
  initial begin
    int rcyc;
    logic [3:0] pat;
    pat = 4'b1001;
    rcyc = 0;
    act_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rcyc++;
      case (ready_mode)
        0:       act_ready = 1'b1;
        1:       act_ready = pat[rcyc % 4];
        default: act_ready = 1'b0;
      endcase
    end
  end

  int checks = 0, errors = 0;
  ent_t got_q[$];
  int   got_cyc[$];
  int   cyc = 0, done_cnt = 0, stab_err = 0, issued = 0, accepted = 0;
  int   max_out = 0, max_addr = 0, zero_busy = 0;
  bit   valid_seen = 0, hold_prev = 0;
  ent_t held;

  always @(negedge clk) begin
    ent_t cur;
    cur.value = act_value;
    cur.row   = act_row;
    cur.col   = act_column;
    cur.last  = act_last;
    cyc++;
    if (!reset_n) begin
      hold_prev = 0;
    end else begin
      if (hold_prev && (!act_valid || cur != held)) stab_err++;
      hold_prev = act_valid && !act_ready;
      held      = cur;
    end
    if (act_valid) valid_seen = 1;
    if (done) done_cnt++;
    if (issued - accepted > max_out) max_out = issued - accepted;
    if (oaram_read_enable) begin
      if (int'(oaram_read_address) > max_addr) max_addr = int'(oaram_read_address);
      if (oaram_read_address != 9'd0) issued++;
      else if (busy) zero_busy++;
    end
    if (act_valid && act_ready) begin
      got_q.push_back(cur);
      got_cyc.push_back(cyc);
      accepted++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic ent_t mk(input int v, input int r, input int c, input int l);
    ent_t e;
    e.value = 16'(v);
    e.row   = 8'(r);
    e.col   = 8'(c);
    e.last  = l[0];
    return e;
  endfunction

  task automatic load_image(input int img);
    for (int i = 0; i < 512; i++) begin
      ram_val[i] = '0;
      ram_idx[i] = '0;
    end
    case (img)
      IMG_DENSE: begin
        ram_val[0] = 25'd4;
        ram_val[1] = 25'd5; ram_idx[1] = 4'd0;
        ram_val[2] = 25'd7; ram_idx[2] = 4'd0;
        ram_val[3] = 25'd9; ram_idx[3] = 4'd2;
        ram_val[4] = 25'd3; ram_idx[4] = 4'd0;
      end
      IMG_WRAP: begin
        ram_val[0] = 25'd4;
        ram_val[1] = 25'd1;  ram_idx[1] = 4'd15;
        ram_val[2] = 25'd2;  ram_idx[2] = 4'd11;
        ram_val[3] = 25'd11; ram_idx[3] = 4'd3;
        ram_val[4] = 25'd6;  ram_idx[4] = 4'd0;
      end
      IMG_PAD: begin
        ram_val[0] = 25'd3;
        ram_val[1] = 25'd0; ram_idx[1] = 4'd15;
        ram_val[2] = 25'd0; ram_idx[2] = 4'd15;
        ram_val[3] = 25'd4; ram_idx[3] = 4'd0;
      end
      IMG_MAX: begin
        ram_val[0] = 25'h1FFFFFF;
        for (int i = 1; i < 512; i++) ram_val[i] = 25'(i);
      end
      default: ram_val[0] = 25'd0;
    endcase
  endtask

  task automatic clear_stats();
    got_q.delete();
    got_cyc.delete();
    done_cnt = 0; stab_err = 0; issued = 0; accepted = 0;
    max_out = 0; max_addr = 0; zero_busy = 0; valid_seen = 0;
  endtask

  task automatic run_image(input logic [1:0] bw, input logic [2:0] k, input int mode,
                           input bit extra, output int lat);
    bit finished;
    @(posedge clk);
    #1;
    clear_stats();
    ready_mode  = mode;
    bitwidth    = bw;
    kernel_size = k;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    bitwidth    = 2'd0;
    kernel_size = 3'd0;
    lat = -1;
    finished = 0;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        finished = 1;
        break;
      end
      @(posedge clk);
      #1;
      start = extra && (n == 3);
    end
    start = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got no done, expected done within 3000 cycles");
    end
    repeat (3) @(negedge clk);
  endtask

  case_t cases[8];

  task automatic compare_case(input int ci, input int lat);
    case_t cs;
    cs = cases[ci];
    check($sformatf("case%0d count", ci), 64'(got_q.size()), 64'(cs.n_exp));
    for (int i = 0; i < int'(cs.n_exp) && i < got_q.size(); i++)
      check($sformatf("case%0d entry%0d", ci, i), 64'(got_q[i]), 64'(cs.ent[i]));
    check($sformatf("case%0d done_pulses", ci), 64'(done_cnt), 64'(1));
    check($sformatf("case%0d stable_hold", ci), 64'(stab_err), 64'(0));
    check($sformatf("case%0d addr0_while_busy", ci), 64'(zero_busy), 64'(0));
    check($sformatf("case%0d busy_after", ci), 64'(busy), 64'(0));
    if (int'(cs.img) != IMG_PAD)
      check($sformatf("case%0d outstanding_gt2", ci), 64'(max_out > 2), 64'(0));
    if (cs.mode == 2'd0)
      for (int i = 1; i < got_cyc.size(); i++)
        check($sformatf("case%0d rate%0d", ci, i), 64'(got_cyc[i] - got_cyc[0]), 64'(i));
    if (int'(cs.img) == IMG_EMPTY) begin
      check("empty done_latency", 64'(lat), 64'(2));
      check("empty valid_seen", 64'(valid_seen), 64'(0));
      check("empty max_addr", 64'(max_addr), 64'(0));
    end
  endtask

  task automatic set_case(input int ci, input int bw, input int k, input int mode,
                          input int img, input int extra, input int n);
    cases[ci]       = '0;
    cases[ci].bw    = 2'(bw);
    cases[ci].k     = 3'(k);
    cases[ci].mode  = 2'(mode);
    cases[ci].img   = 3'(img);
    cases[ci].extra = extra[0];
    cases[ci].n_exp = 3'(n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int lasts;
    bit stalled;

    set_case(0, 2, 3, 0, IMG_DENSE, 0, 4);
    cases[0].ent[0] = mk(5, 1, 1, 0); cases[0].ent[1] = mk(7, 1, 2, 0);
    cases[0].ent[2] = mk(9, 1, 5, 0); cases[0].ent[3] = mk(3, 1, 6, 1);
    set_case(1, 2, 3, 1, IMG_DENSE, 1, 4);
    cases[1].ent = cases[0].ent;
    set_case(2, 1, 5, 0, IMG_DENSE, 0, 4);
    cases[2].ent[0] = mk(5, 2, 2, 0); cases[2].ent[1] = mk(7, 2, 3, 0);
    cases[2].ent[2] = mk(9, 2, 6, 0); cases[2].ent[3] = mk(3, 2, 7, 1);
    set_case(3, 0, 7, 1, IMG_DENSE, 0, 4);
    cases[3].ent[0] = mk(5, 3, 3, 0); cases[3].ent[1] = mk(7, 3, 4, 0);
    cases[3].ent[2] = mk(9, 3, 7, 0); cases[3].ent[3] = mk(3, 3, 8, 1);
    set_case(4, 2, 3, 0, IMG_WRAP, 0, 4);
    cases[4].ent[0] = mk(1, 1, 16, 0); cases[4].ent[1] = mk(2, 1, 28, 0);
    cases[4].ent[2] = mk(11, 2, 2, 0); cases[4].ent[3] = mk(6, 2, 3, 1);
    set_case(5, 2, 3, 1, IMG_PAD, 0, 1);
    cases[5].ent[0] = mk(4, 2, 3, 1);
    set_case(6, 2, 3, 0, IMG_EMPTY, 0, 0);
    set_case(7, 3, 1, 0, IMG_DENSE, 0, 4);
    cases[7].ent[0] = mk(5, 0, 0, 0); cases[7].ent[1] = mk(7, 0, 1, 0);
    cases[7].ent[2] = mk(9, 0, 4, 0); cases[7].ent[3] = mk(3, 0, 5, 1);

    reset_n = 1'b0; start = 1'b0; bitwidth = 2'd0; kernel_size = 3'd3;
    load_image(IMG_EMPTY);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("reset outputs", 64'({act_valid, act_last, busy, done, oaram_read_enable,
                                oaram_read_address, act_value, act_row, act_column}), 64'(0));

    for (int ci = 0; ci < 8; ci++) begin
      load_image(int'(cases[ci].img));
      run_image(cases[ci].bw, cases[ci].k, int'(cases[ci].mode), cases[ci].extra, lat);
      compare_case(ci, lat);
    end

    // Reset in the middle of a stalled stream, then a clean rerun.
    load_image(IMG_DENSE);
    @(posedge clk);
    #1;
    clear_stats();
    ready_mode = 2; bitwidth = 2'd2; kernel_size = 3'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stalled = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (act_valid) begin
        stalled = 1;
        break;
      end
    end
    check("stall valid", 64'(stalled), 64'(1));
    repeat (2) @(negedge clk);
    check("stall hold stable", 64'(stab_err), 64'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    ready_mode = 0;
    @(negedge clk);
    check("midreset outputs", 64'({act_valid, act_last, busy, done, oaram_read_enable,
                                   oaram_read_address, act_value, act_row, act_column}), 64'(0));
    done_cnt = 0;
    valid_seen = 0;
    repeat (5) @(negedge clk);
    check("midreset no_done", 64'(done_cnt), 64'(0));
    check("midreset no_valid", 64'(valid_seen), 64'(0));
    run_image(cases[0].bw, cases[0].k, 0, 0, lat);
    compare_case(0, lat);

    // Maximum-length image: clamped length word, pointer must stop at 511.
    load_image(IMG_MAX);
    run_image(2'd0, 3'd1, 0, 0, lat);
    check("max count", 64'(got_q.size()), 64'(511));
    check("max max_addr", 64'(max_addr), 64'(511));
    check("max addr0_while_busy", 64'(zero_busy), 64'(0));
    check("max done_pulses", 64'(done_cnt), 64'(1));
    lasts = 0;
    foreach (got_q[i]) if (got_q[i].last) lasts++;
    check("max last_flags", 64'(lasts), 64'(1));
    if (got_q.size() == 511) begin
      check("max first", 64'(got_q[0]), 64'(mk(1, 0, 0, 0)));
      check("max row_edge", 64'(got_q[256]), 64'(mk(257, 1, 0, 0)));
      check("max final", 64'(got_q[510]), 64'(mk(511, 1, 254, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
